// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW front end: NOP encoding, bundle geometry and
// the queued bundle record.
package vliw_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0,x0,0
    localparam int          DEF_SLOTS    = 4;
    localparam logic [31:0] BUNDLE_BYTES = 32'(DEF_SLOTS * 4);

    typedef struct packed {
        logic [31:0]                  pc;
        logic [DEF_SLOTS-1:0][31:0]   inst;
    } bundle_t;

    // Clears the byte offset within a bundle of the given slot count.
    function automatic logic [31:0] align_bundle(input logic [31:0] addr, input int slots);
        return addr & ~(32'(slots * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order circular queue of fetched bundles with a combinational head and a
// single-cycle flush that empties it.
module fetch_fifo
    import vliw_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = bundle_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push_ok;
    logic            pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/vliw_fetch_buffer.sv
// Fetch PC generation, credit-limited bundle requests, in-order response
// queueing and per-slot presentation, with redirect flush of stale fetches.
module vliw_fetch_buffer
    import vliw_pkg::*;
#(
    parameter int          NUM_SLOTS = DEF_SLOTS,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [NUM_SLOTS*32-1:0] imem_resp_data,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   bundle_valid,
    output logic [NUM_SLOTS*32-1:0] slot_inst,
    output logic [31:0]            bundle_pc
);

    localparam int          CW   = $clog2(DEPTH + 1);
    localparam logic [31:0] STEP = 32'(NUM_SLOTS * 4);

    typedef struct packed {
        logic [31:0]                pc;
        logic [NUM_SLOTS-1:0][31:0] inst;
    } entry_t;

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   resp_pc_reg;
    logic [31:0]   last_pc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt_reg;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          fifo_empty;
    logic          fifo_full;
    logic          req_fire;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;
    entry_t        head;
    entry_t        push_entry;

    // Queued plus in-flight bundles never exceed DEPTH, so a response always has room.
    assign in_use           = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign imem_req_valid   = rst & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr    = fetch_pc_reg;
    assign req_fire         = imem_req_valid & imem_req_ready;
    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_resp_valid);

    assign resp_drop  = imem_resp_valid & (drop_cnt_reg != '0);
    assign push       = imem_resp_valid & ~resp_drop & ~redirect_valid & ~fifo_full;
    assign pop        = ~stall & ~fifo_empty & ~redirect_valid;
    assign push_entry = '{pc: resp_pc_reg, inst: imem_resp_data};
    assign target_pc  = align_bundle(redirect_pc, NUM_SLOTS);

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            last_pc_reg     <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (!fifo_empty) last_pc_reg <= head.pc;
            if (redirect_valid) begin
                fetch_pc_reg <= target_pc;
                resp_pc_reg  <= target_pc;
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt_reg <= outstanding_next;
            end else begin
                if (req_fire)  fetch_pc_reg <= fetch_pc_reg + STEP;
                if (resp_drop) drop_cnt_reg <= drop_cnt_reg - 1'b1;
                if (push)      resp_pc_reg  <= resp_pc_reg + STEP;
            end
        end
    end

    assign bundle_valid = ~fifo_empty;
    assign bundle_pc    = fifo_empty ? last_pc_reg : head.pc;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign slot_inst[gi*32 +: 32] = fifo_empty ? NOP_INST : head.inst[gi];
        end
    endgenerate

endmodule

// File: tb/tb_vliw_fetch_buffer.sv
// Directed bench for vliw_fetch_buffer: a per-cycle vector table for streaming
// and mid-stream stall, plus hand sequences for stall credits, redirect, reset and wrap.
module tb_vliw_fetch_buffer;

    localparam int NS = 4;
    localparam int W  = NS * 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [31:0]   imem_req_addr;
    logic          imem_resp_valid = 1'b0;
    logic [W-1:0]  imem_resp_data = '0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic          bundle_valid;
    logic [W-1:0]  slot_inst;
    logic [31:0]   bundle_pc;

    int            checks = 0;
    int            errors = 0;
    int            req_count = 0;
    logic          resp_en = 1'b0;
    logic [31:0]   pend[$];

    always #5 clk = ~clk;

    vliw_fetch_buffer #(
        .NUM_SLOTS (NS),
        .DEPTH     (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .bundle_valid    (bundle_valid),
        .slot_inst       (slot_inst),
        .bundle_pc       (bundle_pc)
    );

    // Memory content is a function of the bundle address so misplaced data shows up.
    function automatic logic [W-1:0] mk(input logic [31:0] a);
        logic [W-1:0] r;
        for (int i = 0; i < NS; i++) r[i*32 +: 32] = a + 32'h1000_0000 * 32'(i + 1);
        return r;
    endfunction

    function automatic logic [W-1:0] nops();
        logic [W-1:0] r;
        for (int i = 0; i < NS; i++) r[i*32 +: 32] = 32'h0000_0013;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Called at the negedge: commits this cycle's handshake, then drives the
    // memory response for the following cycle (fixed one-cycle latency when enabled).
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            pend.push_back(a);
            req_count++;
        end
        if (resp_en && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mk(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        stall           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        resp_en         = 1'b0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        req_valid;
        logic [31:0] addr;
        logic        bvalid;
        logic [31:0] bpc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mkv(input logic s, input logic rv, input logic [31:0] ad,
                                 input logic bv, input logic [31:0] pc);
        vec_t v;
        v.stall = s; v.req_valid = rv; v.addr = ad; v.bvalid = bv; v.bpc = pc;
        return v;
    endfunction

    initial begin
        vecs[0]  = mkv(0, 1, 32'h00, 0, 32'h00);
        vecs[1]  = mkv(0, 1, 32'h10, 0, 32'h00);
        vecs[2]  = mkv(0, 1, 32'h20, 1, 32'h00);
        vecs[3]  = mkv(0, 1, 32'h30, 1, 32'h10);
        vecs[4]  = mkv(0, 1, 32'h40, 1, 32'h20);
        vecs[5]  = mkv(0, 1, 32'h50, 1, 32'h30);
        vecs[6]  = mkv(1, 1, 32'h60, 1, 32'h40);
        vecs[7]  = mkv(1, 1, 32'h70, 1, 32'h40);
        vecs[8]  = mkv(1, 0, 32'h80, 1, 32'h40);
        vecs[9]  = mkv(1, 0, 32'h80, 1, 32'h40);
        vecs[10] = mkv(0, 0, 32'h80, 1, 32'h40);
        vecs[11] = mkv(0, 1, 32'h80, 1, 32'h50);
        vecs[12] = mkv(0, 1, 32'h90, 1, 32'h60);
        vecs[13] = mkv(0, 1, 32'hA0, 1, 32'h70);
        vecs[14] = mkv(0, 1, 32'hB0, 1, 32'h80);
        vecs[15] = mkv(0, 1, 32'hC0, 1, 32'h90);

        // Reset state while reset is held.
        #1;
        rst = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        chk("reset req_valid", W'(imem_req_valid), W'(1'b0));
        chk("reset bundle_valid", W'(bundle_valid), W'(1'b0));
        chk("reset slot_inst", slot_inst, nops());
        chk("reset bundle_pc", W'(bundle_pc), W'(32'h0));
        chk("reset req_addr", W'(imem_req_addr), W'(32'h0));

        // Streaming with a mid-stream stall.
        do_reset();
        imem_req_ready = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            stall = vecs[i].stall;
            settle();
            chk($sformatf("vec%0d req_valid", i), W'(imem_req_valid), W'(vecs[i].req_valid));
            chk($sformatf("vec%0d req_addr", i), W'(imem_req_addr), W'(vecs[i].addr));
            chk($sformatf("vec%0d bundle_valid", i), W'(bundle_valid), W'(vecs[i].bvalid));
            if (vecs[i].bvalid) begin
                chk($sformatf("vec%0d bundle_pc", i), W'(bundle_pc), W'(vecs[i].bpc));
                chk($sformatf("vec%0d slot_inst", i), slot_inst, mk(vecs[i].bpc));
            end else begin
                chk($sformatf("vec%0d slot_inst", i), slot_inst, nops());
            end
            tick();
        end

        // Stall from reset: credits allow exactly DEPTH requests, head held.
        do_reset();
        imem_req_ready = 1'b1;
        resp_en = 1'b1;
        stall = 1'b1;
        req_count = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (i >= 2) chk($sformatf("stall%0d head_pc", i), W'(bundle_pc), W'(32'h0));
            tick();
        end
        chk("stall request count", W'(req_count), W'(4));
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("drain%0d bundle_pc", i), W'(bundle_pc), W'(32'h10 * i));
            chk($sformatf("drain%0d slot_inst", i), slot_inst, mk(32'h10 * i));
            tick();
        end

        // Queue empty because memory never accepts.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("empty%0d bundle_valid", i), W'(bundle_valid), W'(1'b0));
            chk($sformatf("empty%0d slot_inst", i), slot_inst, nops());
            chk($sformatf("empty%0d req_valid", i), W'(imem_req_valid), W'(1'b1));
            tick();
        end

        // Redirect with two responses in flight.
        do_reset();
        imem_req_ready = 1'b1;
        settle(); chk("redir r0 addr", W'(imem_req_addr), W'(32'h0)); tick();
        settle(); chk("redir r1 addr", W'(imem_req_addr), W'(32'h10)); tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h107;
        resp_en = 1'b1;
        settle(); chk("redir r2 req_valid", W'(imem_req_valid), W'(1'b0)); tick();
        redirect_valid = 1'b0;
        settle();
        chk("redir r3 req_valid", W'(imem_req_valid), W'(1'b1));
        chk("redir r3 addr", W'(imem_req_addr), W'(32'h100));
        chk("redir r3 bundle_valid", W'(bundle_valid), W'(1'b0));
        chk("redir r3 slot_inst", slot_inst, nops());
        tick();
        settle(); chk("redir r4 bundle_valid", W'(bundle_valid), W'(1'b0)); tick();
        resp_en = 1'b0;
        settle(); chk("redir r5 bundle_valid", W'(bundle_valid), W'(1'b0)); tick();
        stall = 1'b1;
        settle();
        chk("redir r6 bundle_valid", W'(bundle_valid), W'(1'b1));
        chk("redir r6 bundle_pc", W'(bundle_pc), W'(32'h100));
        chk("redir r6 slot_inst", slot_inst, mk(32'h100));
        tick();

        // Asynchronous reset mid-cycle with three requests outstanding.
        #2;
        chk("prereset bundle_valid", W'(bundle_valid), W'(1'b1));
        rst = 1'b0;
        #1;
        chk("async req_valid", W'(imem_req_valid), W'(1'b0));
        chk("async bundle_valid", W'(bundle_valid), W'(1'b0));
        chk("async slot_inst", slot_inst, nops());
        chk("async bundle_pc", W'(bundle_pc), W'(32'h0));
        pend.delete();
        imem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall = 1'b0;
        resp_en = 1'b1;
        settle();
        chk("postreset req_valid", W'(imem_req_valid), W'(1'b1));
        chk("postreset addr", W'(imem_req_addr), W'(32'h0));
        tick();
        settle(); chk("postreset addr2", W'(imem_req_addr), W'(32'h10)); tick();

        // Fetch PC wrap at the top of the address space.
        do_reset();
        imem_req_ready = 1'b1;
        resp_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF5;
        settle(); chk("wrap w0 req_valid", W'(imem_req_valid), W'(1'b0)); tick();
        redirect_valid = 1'b0;
        settle(); chk("wrap w1 addr", W'(imem_req_addr), W'(32'hFFFF_FFF0)); tick();
        settle(); chk("wrap w2 addr", W'(imem_req_addr), W'(32'h0)); tick();
        settle();
        chk("wrap w3 bundle_pc", W'(bundle_pc), W'(32'hFFFF_FFF0));
        chk("wrap w3 slot_inst", slot_inst, mk(32'hFFFF_FFF0));
        tick();
        settle();
        chk("wrap w4 bundle_pc", W'(bundle_pc), W'(32'h0));
        chk("wrap w4 slot_inst", slot_inst, mk(32'h0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
